instr_fetch_unit: RTL and testbench

//  Fetch stage of the MIPS CPU. Holds the PC (reset vector 0xBFC00000) and issues word reads on the

---
 rtl/mips_fetch_pkg.sv | 22 ++
 rtl/fetch_wait_timer.sv | 29 ++
 rtl/instr_fetch_unit.sv | 211 +++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch stage.
package mips_fetch_pkg;

  localparam int          WORD_W         = 32;
  localparam logic [31:0] RESET_VECTOR   = 32'hBFC00000;
  localparam logic [31:0] HALT_ADDR      = 32'h00000000;
  localparam int          TIMEOUT_CYCLES = 64;

  typedef enum logic [2:0] {
    START,
    REQ,
    HOLD,
    CHECK,
    HALTED,
    FAULT
  } fetch_state_t;

  function automatic logic is_word_aligned(input logic [WORD_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts consecutive wait-stated bus cycles; saturates and flags expiry at TIMEOUT_CYCLES.
module fetch_wait_timer #(
  parameter int TIMEOUT_CYCLES = mips_fetch_pkg::TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, single-outstanding instruction-memory read, output
// register towards decode, redirect handling, halt and fault detection.
module instr_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = mips_fetch_pkg::RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR      = mips_fetch_pkg::HALT_ADDR,
  parameter int          TIMEOUT_CYCLES = mips_fetch_pkg::TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [WORD_W-1:0] mem_address,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  logic [WORD_W-1:0] mem_readdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_instr,
  output logic [WORD_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_target,
  output logic              active,
  output logic              fault
);

  fetch_state_t      r_state;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_mem_addr;
  logic              r_mem_read;
  logic              r_out_valid;
  logic [WORD_W-1:0] r_out_instr;
  logic [WORD_W-1:0] r_out_pc;
  logic              r_active;
  logic              r_fault;
  logic              r_pend_vld;
  logic [WORD_W-1:0] r_pend_tgt;

  fetch_state_t      w_state_nxt;
  logic [WORD_W-1:0] w_pc_nxt;
  logic [WORD_W-1:0] w_mem_addr_nxt;
  logic              w_mem_read_nxt;
  logic              w_out_valid_nxt;
  logic [WORD_W-1:0] w_out_instr_nxt;
  logic [WORD_W-1:0] w_out_pc_nxt;
  logic              w_active_nxt;
  logic              w_fault_nxt;
  logic              w_pend_vld_nxt;
  logic [WORD_W-1:0] w_pend_tgt_nxt;
  logic              w_tmr_clear;
  logic              w_tmr_en;
  logic              w_tmr_expired;

  fetch_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_tmr_clear),
    .i_enable (w_tmr_en),
    .o_expired(w_tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= START;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_read_nxt  = r_mem_read;
    w_out_valid_nxt = r_out_valid;
    w_out_instr_nxt = r_out_instr;
    w_out_pc_nxt    = r_out_pc;
    w_active_nxt    = r_active;
    w_fault_nxt     = r_fault;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_tgt_nxt  = r_pend_tgt;
    w_tmr_clear     = 1'b1;
    w_tmr_en        = 1'b0;

    case (r_state)
      START: begin
        w_state_nxt    = REQ;
        w_mem_read_nxt = 1'b1;
        w_mem_addr_nxt = r_pc;
      end

      REQ: begin
        w_tmr_clear = 1'b0;
        if (mem_waitrequest) begin
          if (w_tmr_expired) begin
            w_state_nxt    = FAULT;
            w_mem_read_nxt = 1'b0;
            w_active_nxt   = 1'b0;
            w_fault_nxt    = 1'b1;
          end else begin
            w_tmr_en = 1'b1;
            // The bus transfer cannot be abandoned, so remember where to go once it ends.
            if (redirect_valid) begin
              w_pend_vld_nxt = 1'b1;
              w_pend_tgt_nxt = redirect_target;
            end
          end
        end else begin
          w_tmr_clear    = 1'b1;
          w_mem_read_nxt = 1'b0;
          w_pend_vld_nxt = 1'b0;
          if (redirect_valid) begin
            w_pc_nxt    = redirect_target;
            w_state_nxt = CHECK;
          end else if (r_pend_vld) begin
            w_pc_nxt    = r_pend_tgt;
            w_state_nxt = CHECK;
          end else begin
            w_out_instr_nxt = mem_readdata;
            w_out_pc_nxt    = r_pc;
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = HOLD;
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_pc_nxt        = redirect_valid ? redirect_target : (r_out_pc + 32'd4);
          w_state_nxt     = CHECK;
        end else if (redirect_valid) begin
          w_out_valid_nxt = 1'b0;
          w_pc_nxt        = redirect_target;
          w_state_nxt     = CHECK;
        end
      end

      CHECK: begin
        // A redirect arriving here replaces the PC and is validated on the next cycle.
        if (redirect_valid) begin
          w_pc_nxt = redirect_target;
        end else if (r_pc == HALT_ADDR) begin
          w_state_nxt  = HALTED;
          w_active_nxt = 1'b0;
        end else if (!is_word_aligned(r_pc)) begin
          w_state_nxt  = FAULT;
          w_active_nxt = 1'b0;
          w_fault_nxt  = 1'b1;
        end else begin
          w_state_nxt    = REQ;
          w_mem_read_nxt = 1'b1;
          w_mem_addr_nxt = r_pc;
        end
      end

      HALTED: begin
        w_mem_read_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_active_nxt    = 1'b0;
      end

      FAULT: begin
        w_mem_read_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_active_nxt    = 1'b0;
        w_fault_nxt     = 1'b1;
      end

      default: begin
        w_state_nxt = START;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_VECTOR;
      r_mem_addr  <= RESET_VECTOR;
      r_mem_read  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
      r_active    <= 1'b1;
      r_fault     <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_tgt  <= '0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_instr <= w_out_instr_nxt;
      r_out_pc    <= w_out_pc_nxt;
      r_active    <= w_active_nxt;
      r_fault     <= w_fault_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_tgt  <= w_pend_tgt_nxt;
    end
  end

  assign mem_address = r_mem_addr;
  assign mem_read    = r_mem_read;
  assign out_valid   = r_out_valid;
  assign out_instr   = r_out_instr;
  assign out_pc      = r_out_pc;
  assign active      = r_active;
  assign fault       = r_fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run against a
// program-flow reference model (expected next PC, stale in-flight read tracking).
module tb_instr_fetch_unit;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        active;
  logic        fault;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_waitrequest(mem_waitrequest),
    .mem_readdata   (mem_readdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .active         (active),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    mem_waitrequest = 1'b0;
    mem_readdata    = 32'h0;
    out_ready       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %0b want 0", mem_read); end
    checks++; if (mem_address !== RV) begin errors++; $display("FAIL reset_addr got %h want %h", mem_address, RV); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_instr !== 32'h0 || out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h/%h want 0/0", out_instr, out_pc); end
    checks++; if (active !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL reset_status got active=%0b fault=%0b want 1/0", active, fault); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_fetch();
    apply_reset();
    mem_readdata = 32'h24020005;
    out_ready    = 1'b1;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL t1_start_idle got %0b want 0", mem_read); end
    tick();
    checks++; if (mem_read !== 1'b1 || mem_address !== RV) begin errors++; $display("FAIL t1_first_req got %0b/%h want 1/%h", mem_read, mem_address, RV); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== RV || out_instr !== 32'h24020005) begin errors++; $display("FAIL t1_deliver got %0b/%h/%h want 1/%h/24020005", out_valid, out_pc, out_instr, RV); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL t1_no_prefetch got %0b want 0", mem_read); end
    tick();
    checks++; if (out_valid !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL t1_check_cycle got %0b/%0b want 0/0", out_valid, mem_read); end
    tick();
    checks++; if (mem_read !== 1'b1 || mem_address !== RV + 32'd4) begin errors++; $display("FAIL t1_next_req got %0b/%h want 1/%h", mem_read, mem_address, RV + 32'd4); end
  endtask

  task automatic test_wait_states();
    apply_reset();
    mem_waitrequest = 1'b1;
    mem_readdata    = 32'h8C430010;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (mem_read !== 1'b1 || mem_address !== RV || out_valid !== 1'b0) begin errors++; $display("FAIL t2_hold%0d got %0b/%h/%0b want 1/%h/0", i, mem_read, mem_address, out_valid, RV); end
    end
    mem_waitrequest = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h8C430010 || out_pc !== RV) begin errors++; $display("FAIL t2_deliver got %0b/%h/%h want 1/8c430010/%h", out_valid, out_instr, out_pc, RV); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    mem_waitrequest = 1'b1;
    repeat (62) tick();
    checks++; if (fault !== 1'b0 || mem_read !== 1'b1 || mem_address !== RV + 32'd4) begin errors++; $display("FAIL t2_timer_cleared got fault=%0b rd=%0b addr=%h want 0/1/%h", fault, mem_read, mem_address, RV + 32'd4); end
    mem_waitrequest = 1'b0;
    mem_readdata    = 32'h00851020;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== RV + 32'd4 || out_instr !== 32'h00851020) begin errors++; $display("FAIL t2_second got %0b/%h/%h want 1/%h/00851020", out_valid, out_pc, out_instr, RV + 32'd4); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    mem_readdata = 32'h3C01BFC0;
    tick();
    tick();
    mem_readdata = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_instr !== 32'h3C01BFC0 || out_pc !== RV || mem_read !== 1'b0) begin errors++; $display("FAIL t3_stall%0d got %0b/%h/%h rd=%0b want 1/3c01bfc0/%h rd=0", i, out_valid, out_instr, out_pc, mem_read, RV); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t3_accept got %0b want 0", out_valid); end
    tick();
    checks++; if (mem_read !== 1'b1 || mem_address !== RV + 32'd4) begin errors++; $display("FAIL t3_next_req got %0b/%h want 1/%h", mem_read, mem_address, RV + 32'd4); end
  endtask

  task automatic test_redirect_waited();
    apply_reset();
    mem_waitrequest = 1'b1;
    mem_readdata    = 32'h11111111;
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'hBFC00100;
    tick();
    redirect_valid = 1'b0;
    tick();
    mem_waitrequest = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL t4_discard got %0b/%0b want 0/0", out_valid, mem_read); end
    tick();
    checks++; if (mem_read !== 1'b1 || mem_address !== 32'hBFC00100 || out_valid !== 1'b0) begin errors++; $display("FAIL t4_target_req got %0b/%h/%0b want 1/bfc00100/0", mem_read, mem_address, out_valid); end
    mem_readdata = 32'h22222222;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'hBFC00100 || out_instr !== 32'h22222222) begin errors++; $display("FAIL t4_target_data got %0b/%h/%h want 1/bfc00100/22222222", out_valid, out_pc, out_instr); end
  endtask

  task automatic test_halt_and_misalign();
    apply_reset();
    tick();
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h00000000;
    tick();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t5_drop got %0b want 0", out_valid); end
    tick();
    checks++; if (active !== 1'b0 || fault !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL t5_halted got act=%0b fault=%0b rd=%0b want 0/0/0", active, fault, mem_read); end
    redirect_valid  = 1'b1;
    redirect_target = RV;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (active !== 1'b0 || mem_read !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL t5_halt_sticky%0d got act=%0b rd=%0b vld=%0b want 0/0/0", i, active, mem_read, out_valid); end
    end
    redirect_valid = 1'b0;
    apply_reset();
    tick();
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'hBFC00102;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++; if (fault !== 1'b1 || active !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL t5_misalign got fault=%0b act=%0b rd=%0b want 1/0/0", fault, active, mem_read); end
    repeat (3) tick();
    checks++; if (fault !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL t5_fault_sticky got fault=%0b rd=%0b want 1/0", fault, mem_read); end
  endtask

  task automatic test_pc_wrap();
    apply_reset();
    tick();
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFFFFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++; if (mem_read !== 1'b1 || mem_address !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_req got %0b/%h want 1/fffffffc", mem_read, mem_address); end
    mem_readdata = 32'h0000000C;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    checks++; if (active !== 1'b0 || fault !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL wrap_halt got act=%0b fault=%0b rd=%0b want 0/0/0", active, fault, mem_read); end
  endtask

  task automatic test_timeout_and_reset();
    apply_reset();
    mem_waitrequest = 1'b1;
    tick();
    repeat (64) tick();
    checks++; if (fault !== 1'b0 || mem_read !== 1'b1) begin errors++; $display("FAIL t6_before_timeout got fault=%0b rd=%0b want 0/1", fault, mem_read); end
    tick();
    checks++; if (fault !== 1'b1 || mem_read !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL t6_timeout got fault=%0b rd=%0b act=%0b want 1/0/0", fault, mem_read, active); end
    apply_reset();
    mem_waitrequest = 1'b1;
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'hBFC00200;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #2;
    checks++; if (mem_read !== 1'b0 || mem_address !== RV || out_valid !== 1'b0 || active !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL t6_midwait_reset got rd=%0b addr=%h vld=%0b act=%0b fault=%0b", mem_read, mem_address, out_valid, active, fault); end
    mem_waitrequest = 1'b0;
    mem_readdata    = 32'h24020005;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (mem_read !== 1'b1 || mem_address !== RV) begin errors++; $display("FAIL t6_refetch got %0b/%h want 1/%h", mem_read, mem_address, RV); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== RV || out_instr !== 32'h24020005) begin errors++; $display("FAIL t6_refetch_data got %0b/%h/%h want 1/%h/24020005", out_valid, out_pc, out_instr, RV); end
  endtask

  task automatic test_random();
    logic [31:0] exp_next, p_addr, p_out_pc, p_out_instr, rt;
    logic        p_mem_read, p_out_valid, wr, rv, rdy, stale;
    int          wait_run, delivered;
    apply_reset();
    exp_next     = RV;
    stale        = 1'b0;
    wait_run     = 0;
    delivered    = 0;
    mem_readdata = word_of(mem_address);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      p_mem_read  = mem_read;
      p_addr      = mem_address;
      p_out_valid = out_valid;
      p_out_pc    = out_pc;
      p_out_instr = out_instr;
      wr  = mem_waitrequest;
      rv  = redirect_valid;
      rt  = redirect_target;
      rdy = out_ready;
      tick();
      if (p_out_valid && rdy) begin
        checks++; if (p_out_pc !== exp_next || p_out_instr !== word_of(p_out_pc)) begin errors++; $display("FAIL rnd_accept cyc%0d got %h/%h want %h/%h", cyc, p_out_pc, p_out_instr, exp_next, word_of(exp_next)); end
        exp_next = rv ? rt : p_out_pc + 32'd4;
        delivered++;
      end else if (p_out_valid && rv) begin
        exp_next = rt;
      end else if (p_mem_read) begin
        if (!stale) begin
          checks++; if (p_addr !== exp_next) begin errors++; $display("FAIL rnd_addr cyc%0d got %h want %h", cyc, p_addr, exp_next); end
        end
        if (rv) begin
          exp_next = rt;
          stale    = 1'b1;
        end
        if (wr) begin
          checks++; if (mem_read !== 1'b1 || mem_address !== p_addr) begin errors++; $display("FAIL rnd_bus_hold cyc%0d got %0b/%h want 1/%h", cyc, mem_read, mem_address, p_addr); end
        end else begin
          stale = 1'b0;
        end
      end
      checks++; if (active !== 1'b1 || fault !== 1'b0 || (mem_read && out_valid)) begin errors++; $display("FAIL rnd_status cyc%0d got act=%0b fault=%0b rd=%0b vld=%0b", cyc, active, fault, mem_read, out_valid); end
      if (out_valid && !p_out_valid) begin
        checks++; if (out_pc !== exp_next || out_instr !== word_of(out_pc)) begin errors++; $display("FAIL rnd_capture cyc%0d got %h/%h want %h/%h", cyc, out_pc, out_instr, exp_next, word_of(exp_next)); end
      end
      rdy = ($urandom_range(0, 2) != 0);
      if (mem_read) begin
        wr       = (wait_run >= 8) ? 1'b0 : ($urandom_range(0, 2) == 0);
        wait_run = wr ? wait_run + 1 : 0;
      end else begin
        wr       = 1'($urandom_range(0, 1));
        wait_run = 0;
      end
      rv = (mem_read || out_valid) && ($urandom_range(0, 9) == 0);
      rt = RV | (32'($urandom_range(0, 1023)) << 2);
      mem_waitrequest = wr;
      out_ready       = rdy;
      redirect_valid  = rv;
      redirect_target = rt;
      mem_readdata    = word_of(mem_address);
    end
    checks++; if (delivered < 50) begin errors++; $display("FAIL rnd_progress got %0d want >=50", delivered); end
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    mem_waitrequest = 1'b0;
    mem_readdata    = 32'h0;
    out_ready       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    test_reset();
    test_first_fetch();
    test_wait_states();
    test_backpressure();
    test_redirect_waited();
    test_halt_and_misalign();
    test_pc_wrap();
    test_timeout_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
